// File: rtl/bram_stream_ctrl.sv
// bram_stream_ctrl: streams bytes into sequential BRAM addresses and runs read bursts back out.
// Define BRAM_CTRL_CHECKSUM_EN to add rd_csum, the modulo byte sum of the current burst.
module bram_stream_ctrl #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ptr_clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_wrapped,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] rd_len,
    output logic              rd_busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_done,
`ifdef BRAM_CTRL_CHECKSUM_EN
    output logic [DATA_W-1:0] rd_csum,
`endif
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    // Tag stages from address issue to rd_valid: mem_addr register, BRAM sample, RD_LAT output delay.
    localparam int unsigned TAG_D  = RD_LAT + 2;
    localparam int unsigned DCNT_W = $clog2(RD_LAT + 3);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state, state_nx;
    logic              rd_accept, wr_accept, issue, drain_end;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] base, cnt;
    logic [DCNT_W-1:0] dcnt;
    logic [TAG_D-1:0]  tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, handshake decode and read address issue
    always_comb begin
        state_nx   = state;
        rd_accept  = 1'b0;
        wr_accept  = 1'b0;
        issue      = 1'b0;
        drain_end  = 1'b0;
        wr_ready   = 1'b0;
        rd_busy    = 1'b1;
        issue_addr = base;
        case (state)
            IDLE: begin
                rd_busy    = 1'b0;
                wr_ready   = !rd_start;
                wr_accept  = wr_valid && !rd_start;
                issue_addr = rd_addr;
                // A start coinciding with the done pulse is dropped
                if (rd_start && !rd_done) begin
                    rd_accept = 1'b1;
                    if (rd_len != '0) begin
                        issue    = 1'b1;
                        state_nx = READ;
                    end else begin
                        state_nx = DRAIN;
                    end
                end
            end
            READ: begin
                if (cnt == ADDR_W'(1)) begin
                    state_nx = DRAIN;
                end else begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == DRAIN_LAST) begin
                    drain_end = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // BRAM port, write pointer and burst bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_mode   <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            wr_ptr     <= '0;
            wr_wrapped <= 1'b0;
            base       <= '0;
            cnt        <= '0;
            dcnt       <= '0;
        end else begin
            mem_mode <= wr_accept;
            if (wr_accept) begin
                mem_addr <= wr_ptr;
                mem_din  <= wr_data;
                if (wr_ptr == '1) begin
                    wr_wrapped <= 1'b1;
                end
            end else if (issue) begin
                mem_addr <= issue_addr;
            end

            if (state == IDLE && wr_ptr_clr) begin
                wr_ptr <= '0;
            end else if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            if (rd_accept) begin
                base <= rd_addr + ADDR_W'(1);
                cnt  <= rd_len;
            end else if (issue) begin
                base <= base + ADDR_W'(1);
                cnt  <= cnt - ADDR_W'(1);
            end

            if (state_nx == DRAIN && state != DRAIN) begin
                dcnt <= '0;
            end else if (state == DRAIN) begin
                dcnt <= dcnt + DCNT_W'(1);
            end
        end
    end

    // Return path: tags follow each issued address until its byte reaches mem_dout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_done  <= 1'b0;
        end else begin
            tag      <= {tag[TAG_D-2:0], issue};
            rd_valid <= tag[TAG_D-1];
            rd_done  <= drain_end;
            if (tag[TAG_D-1]) begin
                rd_data <= mem_dout;
            end
        end
    end

`ifdef BRAM_CTRL_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_csum <= '0;
        end else if (rd_accept) begin
            rd_csum <= '0;
        end else if (tag[TAG_D-1]) begin
            rd_csum <= rd_csum + mem_dout;
        end
    end
`endif

endmodule
